fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch front end of the 5-stage RV64 core; sits directly upstream of the F/D pipeline register.
//  Owns the fetch PC and issues PC+4 sequential reads to the synchronous (1-cycle) instruction memory.
//  Buffers returned words in a small FIFO, and presents {pc, instr} to F/D with a valid/ready handshake.
//  Accepts branch redirects from execute/memory; on a redirect it squashes all wrong-path state.
// PARAMETERS
//  PC_W        64    fetch PC / address width
//  INSTR_W     32    instruction word width
//  RESET_PC    0     PC fetched first after reset (bits [1:0] must be 0)
//  FIFO_DEPTH  2     output buffer entries; >=2, power of 2
// PORTS
//  clk_i           in   1        clock, all state on rising edge
//  reset_i         in   1        synchronous, active-high reset
//  redirect_i      in   1        branch taken: restart fetch at redirect_pc_i
//  redirect_pc_i   in   PC_W     redirect target; bits [1:0] ignored (treated as 0)
//  imem_rd_valid_o out  1        read request strobe to instruction memory
//  imem_rd_addr_o  out  PC_W     read address (= fetch PC)
//  imem_rd_data_i  in   INSTR_W  read data, valid the cycle after the request
//  valid_o         out  1        {pc_o, instr_o} valid toward F/D
//  ready_i         in   1        F/D accepts this cycle
//  pc_o            out  PC_W     PC of presented instruction
//  instr_o         out  INSTR_W  presented instruction
//  stall_o         out  1        1 when a request was withheld for lack of buffer credit
// BEHAVIOUR
//  State: fetch_pc, inflight (request issued last cycle), inflight_pc, squash, FIFO {pc,instr} x FIFO_DEPTH, count.
//  Reset (reset_i=1 at edge):
//   - fetch_pc=RESET_PC; inflight=0; squash=0; count=0.
//   - FIFO pointers=0; valid_o=0, stall_o=0, imem_rd_valid_o=0.
//   - pc_o/instr_o=0; reset overrides redirect and any in-flight read.
//  deq = valid_o & ready_i. valid_o = (count!=0). pc_o/instr_o = FIFO head.
//  Issue rule, combinational:
//   - imem_rd_valid_o = !reset_i & !redirect_i & (count + inflight - deq < FIFO_DEPTH).
//   - imem_rd_addr_o = fetch_pc.
//   - stall_o = !reset_i & !redirect_i & !imem_rd_valid_o.
//  On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^PC_W, wraps silently).
//  No issue: inflight<=0, fetch_pc holds.
//  Response: if inflight & !squash & !redirect_i, push {inflight_pc, imem_rd_data_i} at this edge.
//  Latency: request at cycle T -> data at T+1 -> pushed at end of T+1 -> valid_o at T+2.
//  Credit rule guarantees push never hits a full FIFO. Push and pop in the same cycle: count unchanged.
//  Redirect (redirect_i=1 at edge):
//   - FIFO flushed, count=0; fetch_pc<=redirect_pc_i & ~3.
//   - No issue this cycle; a response arriving this cycle is dropped.
//   - deq in the redirect cycle still counts as consumed by F/D; F/D flush is external.
//   - First correct-path valid_o 3 cycles after the redirect edge.
//  squash: set only if a redirect lands with a read still pending in the next cycle; cleared after one cycle.
//   With the no-issue rule squash stays 0; kept as a guard and asserted never 1 in sim.
//  Back-to-back redirects: the last one wins; each fully restarts.
//  Backpressure: ready_i=0 holds FIFO head stable (pc_o, instr_o unchanged while valid_o=1).
//  Handshake: no combinational path ready_i->valid_o. ready_i->imem_rd_valid_o is allowed.
// TESTING
//  1 reset, RESET_PC=0x100, ready_i=1, imem returns addr>>2:
//    - imem addrs 0x100,0x104,0x108 on cycles 0,1,2.
//    - valid_o from cycle 2, pc_o 0x100,0x104,... one per cycle, no stall_o.
//  2 streaming, then ready_i=0 for 5 cycles:
//    - FIFO fills to 2, stall_o=1, imem_rd_valid_o=0.
//    - pc_o/instr_o frozen; on ready_i=1, in-order resume with no PC skipped or duplicated.
//  3 redirect_i=1, redirect_pc_i=0x2003, with a read in flight:
//    - in-flight word dropped; next imem addr 0x2000.
//    - valid_o low 3 cycles, then pc_o=0x2000, 0x2004.
//  4 redirect in the same cycle as deq, FIFO count=2:
//    - FIFO empty next cycle; no stale pc_o appears after the redirect.
//  5 reset_i asserted mid-stream, FIFO full, read in flight:
//    - next cycle valid_o=0, count=0; fetch restarts at RESET_PC; stale data never presented.
//  6 fetch_pc=2^64-4:
//    - next request addr=0 (wrap); redirects on consecutive cycles, last target only fetched.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC and issues sequential reads to a 1-cycle imem.
// Buffers returned words in a small FIFO and presents {pc, instr} to F/D with valid/ready.
module fetch_stage #(
  parameter int unsigned     PC_W       = 64,
  parameter int unsigned     INSTR_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_rd_valid_o,
  output logic [PC_W-1:0]    imem_rd_addr_o,
  input  logic [INSTR_W-1:0] imem_rd_data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               stall_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [PC_W-1:0]   fetch_pc_q;
  logic [PC_W-1:0]   inflight_pc_q;
  logic              inflight_q;
  logic              squash_q;

  logic              deq;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    credit_used;

  // Credit check counts the in-flight read so a response always finds room
  assign valid_o     = (count_q != '0);
  assign deq         = valid_o & ready_i;
  assign credit_used = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(deq);
  assign issue       = !reset_i && !redirect_i && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  assign imem_rd_valid_o = issue;
  assign imem_rd_addr_o  = fetch_pc_q;
  assign stall_o         = !reset_i && !redirect_i && !issue;

  assign push    = inflight_q && !squash_q && !redirect_i;
  assign pc_o    = fifo_q[rd_ptr_q].pc;
  assign instr_o = fifo_q[rd_ptr_q].instr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_q        <= '{default: '0};
    end else begin
      inflight_q <= issue;
      squash_q   <= redirect_i && issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + PC_W'(4);
      end
      if (redirect_i) begin
        // Wrong-path flush: buffered words and any arriving response are discarded
        fetch_pc_q <= redirect_pc_i & ~PC_W'(3);
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q].pc    <= inflight_pc_q;
          fifo_q[wr_ptr_q].instr <= imem_rd_data_i;
          wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(deq);
      end
    end
  end

`ifndef SYNTHESIS
  // Redirects never issue, so no read can be pending behind one
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!squash_q);
    end
  end
`endif

endmodule
